// File: rtl/jesd_tx_pkg.sv
// Shared octet constants and link-state encoding
// for the JESD204B-style transmit link layer.
package jesd_tx_pkg;

   localparam logic [7:0] K28_0 = 8'h1C;
   localparam logic [7:0] K28_3 = 8'h7C;
   localparam logic [7:0] K28_4 = 8'h9C;
   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K28_7 = 8'hFC;

   localparam int ILAS_MULTIFRAMES = 4;
   localparam int CONFIG_OCTETS    = 14;

   typedef enum logic [1:0] {
      LINK_CGS  = 2'd0,
      LINK_ILAS = 2'd1,
      LINK_DATA = 2'd2
   } link_state_e;

   function automatic logic [31:0] rep4(input logic [7:0] o);
      return {4{o}};
   endfunction

endpackage

// File: rtl/jesd_tx_lmfc.sv
// Local multiframe counter; a SYSREF rising edge
// forces the next count to zero.
module jesd_tx_lmfc
   import jesd_tx_pkg::*;
#(
   parameter int K = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sysref,
   output logic [4:0] lmfc_cnt,
   output logic       lmfc_pulse,
   output logic       realign
);

   localparam logic [4:0] LAST = 5'(K - 1);

   logic sysref_d;

   assign realign    = sysref && !sysref_d;
   assign lmfc_pulse = (lmfc_cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lmfc_cnt <= '0;
         sysref_d <= 1'b0;
      end else begin
         sysref_d <= sysref;
         if (realign || lmfc_pulse)
            lmfc_cnt <= '0;
         else
            lmfc_cnt <= lmfc_cnt + 5'd1;
      end
   end

endmodule

// File: rtl/jesd_tx_link_layer.sv
// Single-lane TX link layer: CGS, ILAS and DATA with
// end-of-frame character replacement, F=4.
module jesd_tx_link_layer
   import jesd_tx_pkg::*;
#(
   parameter int g_FramesPerMulti = 32
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         SYNC_N,
   input  logic         SYSREF,
   input  logic [111:0] Config_Octets,
   input  logic [31:0]  Input_Data,
   output logic         Input_Data_Read,
   output logic [31:0]  Tx_Data,
   output logic [3:0]   Tx_K,
   output logic         LMFC_Pulse,
   output logic [1:0]   Link_State
);

   localparam logic [1:0] ST_CGS  = LINK_CGS;
   localparam logic [1:0] ST_ILAS = LINK_ILAS;
   localparam logic [1:0] ST_DATA = LINK_DATA;

   localparam logic [6:0] ILAS_LAST = 7'(4 * g_FramesPerMulti - 1);
   localparam logic [6:0] CFG_END   = 7'(2 + CONFIG_OCTETS);
   localparam logic [1:0] MF_LAST   = 2'(ILAS_MULTIFRAMES - 1);

   logic        sync_m;
   logic        sync_s;
   logic [1:0]  state;
   logic [1:0]  mf;
   logic [4:0]  lmfc_cnt;
   logic        realign;
   logic        ilas_out;
   logic        data_out;
   logic [7:0]  prev_end;
   logic        prev_ok;
   logic [6:0]  idx;
   logic [3:0]  cidx;
   logic [7:0]  oct;
   logic        okf;
   logic [31:0] ilas_data;
   logic [3:0]  ilas_k;
   logic [31:0] data_data;
   logic [3:0]  data_k;
   logic [31:0] nxt_data;
   logic [3:0]  nxt_k;

   jesd_tx_lmfc #(
      .K(g_FramesPerMulti)
   ) u_lmfc (
      .clk       (Clock),
      .rst       (Reset),
      .sysref    (SYSREF),
      .lmfc_cnt  (lmfc_cnt),
      .lmfc_pulse(LMFC_Pulse),
      .realign   (realign)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)
         {sync_s, sync_m} <= 2'b00;
      else
         {sync_s, sync_m} <= {sync_m, SYNC_N};
   end

   // A dropped SYNC~ silences the lane in the very cycle it is seen
   assign ilas_out        = (state == ST_ILAS) && sync_s;
   assign data_out        = (state == ST_DATA) && sync_s;
   assign Input_Data_Read = data_out;
   assign Link_State      = state;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= ST_CGS;
         mf    <= '0;
      end else begin
         case (state)
            ST_CGS: begin
               if (sync_s && LMFC_Pulse) begin
                  state <= ST_ILAS;
                  mf    <= '0;
               end
            end
            ST_ILAS: begin
               if (!sync_s)
                  state <= ST_CGS;
               else if (realign)
                  mf <= '0;
               else if (LMFC_Pulse) begin
                  if (mf == MF_LAST)
                     state <= ST_DATA;
                  mf <= mf + 2'd1;
               end
            end
            ST_DATA: begin
               if (!sync_s)
                  state <= ST_CGS;
            end
            default: state <= ST_CGS;
         endcase
      end
   end

   // /A/ outranks config so a short multiframe still ends on /A/
   always_comb begin
      ilas_data = '0;
      ilas_k    = '0;
      idx       = '0;
      cidx      = '0;
      oct       = '0;
      okf       = 1'b0;
      for (int p = 0; p < 4; p++) begin
         idx  = {lmfc_cnt, 2'(p)};
         cidx = 4'(idx - 7'd2);
         oct  = {1'b0, idx};
         okf  = 1'b0;
         if (idx == 7'd0) begin
            oct = K28_0;
            okf = 1'b1;
         end else if (idx == ILAS_LAST) begin
            oct = K28_3;
            okf = 1'b1;
         end else if (mf == 2'd0 && idx == 7'd1) begin
            oct = K28_4;
            okf = 1'b1;
         end else if (mf == 2'd0 && idx < CFG_END) begin
            oct = Config_Octets[{cidx, 3'b000} +: 8];
         end
         ilas_data[8*p +: 8] = oct;
         ilas_k[p]           = okf;
      end
   end

   always_comb begin
      data_data = Input_Data;
      data_k    = 4'b0000;
      if (prev_ok && Input_Data[31:24] == prev_end) begin
         data_data[31:24] = LMFC_Pulse ? K28_3 : K28_7;
         data_k[3]        = 1'b1;
      end
   end

   always_comb begin
      nxt_data = rep4(K28_5);
      nxt_k    = 4'hF;
      if (ilas_out) begin
         nxt_data = ilas_data;
         nxt_k    = ilas_k;
      end else if (data_out) begin
         nxt_data = data_data;
         nxt_k    = data_k;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         prev_end <= '0;
         prev_ok  <= 1'b0;
      end else begin
         prev_ok <= data_out;
         if (data_out)
            prev_end <= Input_Data[31:24];
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         Tx_Data <= rep4(K28_5);
         Tx_K    <= 4'hF;
      end else begin
         Tx_Data <= nxt_data;
         Tx_K    <= nxt_k;
      end
   end

endmodule

// File: tb/tb_jesd_tx_link_layer.sv
// Bench for jesd_tx_link_layer: K=32 and K=4 lanes share
// stimulus and are checked against a frame-level model.
module tb_jesd_tx_link_layer;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         sync_n = 1'b0;
   logic         sysref = 1'b0;
   logic [111:0] cfg = '0;
   logic [31:0]  din = '0;

   logic         rd  [2];
   logic [31:0]  txd [2];
   logic [3:0]   txk [2];
   logic         pls [2];
   logic [1:0]   ls  [2];

   int vectors = 0;
   int miscompares = 0;

   int          m_state [2];
   int          m_lmfc  [2];
   int          m_frame [2];
   bit          m_hp    [2];
   logic [7:0]  m_prev  [2];
   logic [31:0] e_data  [2];
   logic [3:0]  e_k     [2];
   bit          m_s1, m_s2, m_srd;

   always #5 clk = ~clk;

   jesd_tx_link_layer #(.g_FramesPerMulti(32)) dut0 (
      .Clock(clk), .Reset(rst), .SYNC_N(sync_n), .SYSREF(sysref),
      .Config_Octets(cfg), .Input_Data(din),
      .Input_Data_Read(rd[0]), .Tx_Data(txd[0]), .Tx_K(txk[0]),
      .LMFC_Pulse(pls[0]), .Link_State(ls[0])
   );

   jesd_tx_link_layer #(.g_FramesPerMulti(4)) dut1 (
      .Clock(clk), .Reset(rst), .SYNC_N(sync_n), .SYSREF(sysref),
      .Config_Octets(cfg), .Input_Data(din),
      .Input_Data_Read(rd[1]), .Tx_Data(txd[1]), .Tx_K(txk[1]),
      .LMFC_Pulse(pls[1]), .Link_State(ls[1])
   );

   function automatic int kof(input int d);
      return (d == 0) ? 32 : 4;
   endfunction

   // ILAS octets from the absolute octet position in the sequence
   function automatic void ilas_frame(input int k, input int f,
                                      output logic [31:0] dat,
                                      output logic [3:0] kf);
      dat = '0;
      kf  = '0;
      for (int p = 0; p < 4; p++) begin
         int o;
         int mfi;
         int i;
         logic [7:0] b;
         logic kb;
         o   = 4 * f + p;
         mfi = o / (4 * k);
         i   = o % (4 * k);
         b   = 8'(i);
         kb  = 1'b0;
         if (i == 0) begin
            b = 8'h1C; kb = 1'b1;
         end else if (i == 4 * k - 1) begin
            b = 8'h7C; kb = 1'b1;
         end else if (mfi == 0 && i == 1) begin
            b = 8'h9C; kb = 1'b1;
         end else if (mfi == 0 && i >= 2 && i < 16) begin
            b = cfg[8*(i-2) +: 8];
         end
         dat[8*p +: 8] = b;
         kf[p] = kb;
      end
   endfunction

   task automatic model_reset();
      m_s1 = 1'b0;
      m_s2 = 1'b0;
      m_srd = 1'b0;
      for (int d = 0; d < 2; d++) begin
         m_state[d] = 0;
         m_lmfc[d]  = 0;
         m_frame[d] = 0;
         m_hp[d]    = 1'b0;
         m_prev[d]  = '0;
         e_data[d]  = 32'hBCBCBCBC;
         e_k[d]     = 4'hF;
      end
   endtask

   task automatic model_step();
      bit rise;
      bit ss;
      if (rst) begin
         model_reset();
         return;
      end
      rise = sysref && !m_srd;
      ss   = m_s2;
      for (int d = 0; d < 2; d++) begin
         int k;
         logic [31:0] od;
         logic [3:0] okk;
         k   = kof(d);
         od  = 32'hBCBCBCBC;
         okk = 4'hF;
         if (m_state[d] == 1 && ss) begin
            ilas_frame(k, m_frame[d], od, okk);
         end else if (m_state[d] == 2 && ss) begin
            od  = din;
            okk = 4'h0;
            if (m_hp[d] && din[31:24] == m_prev[d]) begin
               od[31:24] = (m_lmfc[d] == k - 1) ? 8'h7C : 8'hFC;
               okk = 4'h8;
            end
         end
         e_data[d] = od;
         e_k[d]    = okk;
         m_hp[d]   = (m_state[d] == 2 && ss);
         if (m_hp[d]) m_prev[d] = din[31:24];
         case (m_state[d])
            0: if (ss && m_lmfc[d] == k - 1) begin
                  m_state[d] = 1;
                  m_frame[d] = 0;
               end
            1: if (!ss) m_state[d] = 0;
               else if (rise) m_frame[d] = 0;
               else if (m_frame[d] == 4 * k - 1) m_state[d] = 2;
               else m_frame[d] = m_frame[d] + 1;
            2: if (!ss) m_state[d] = 0;
            default: m_state[d] = 0;
         endcase
         m_lmfc[d] = rise ? 0 : (m_lmfc[d] + 1) % k;
      end
      m_s2  = m_s1;
      m_s1  = sync_n;
      m_srd = sysref;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("tx_data[%0d]", d), txd[d], e_data[d]);
         chk($sformatf("tx_k[%0d]", d), 32'(txk[d]), 32'(e_k[d]));
         chk($sformatf("link_state[%0d]", d), 32'(ls[d]), 32'(m_state[d]));
         chk($sformatf("read[%0d]", d), 32'(rd[d]),
             32'(m_state[d] == 2 && m_s2));
         chk($sformatf("lmfc_pulse[%0d]", d), 32'(pls[d]),
             32'(m_lmfc[d] == kof(d) - 1));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #2;
      check_all();
   endtask

   task automatic run(input int n, input int sr_div);
      for (int i = 0; i < n; i++) begin
         logic [31:0] v;
         v = $urandom;
         if ($urandom_range(0, 1) == 1) v[31:24] = din[31:24];
         din = v;
         sysref = (sr_div != 0) && ($urandom_range(0, sr_div - 1) == 0);
         tick();
      end
      sysref = 1'b0;
   endtask

   task automatic wait_lmfc(input int d, input int v);
      for (int i = 0; i < 64 && m_lmfc[d] != v; i++) tick();
   endtask

   task automatic wait_state(input int d, input int st, input int lim);
      for (int i = 0; i < lim && m_state[d] != st; i++) tick();
      chk($sformatf("wait_state%0d[%0d]", st, d), 32'(ls[d]), 32'(st));
   endtask

   initial begin
      cfg = {$urandom, $urandom, $urandom, 16'($urandom)};
      din = $urandom;
      #1 rst = 1'b1;
      model_reset();
      #1;
      check_all();
      chk("rst_tx_data", txd[0], 32'hBCBCBCBC);
      chk("rst_tx_k", 32'(txk[0]), 32'hF);
      repeat (3) tick();
      rst = 1'b0;

      // CGS while the receiver holds SYNC~ low
      repeat (100) tick();
      chk("cgs_tx_data", txd[0], 32'hBCBCBCBC);
      chk("cgs_tx_k", 32'(txk[0]), 32'hF);
      chk("cgs_state", 32'(ls[0]), 32'd0);
      chk("cgs_read", 32'(rd[0]), 32'd0);

      // Release at lmfc 10; ILAS waits for the next boundary
      wait_lmfc(0, 10);
      sync_n = 1'b1;
      wait_state(0, 1, 100);
      tick();
      chk("ilas_first", txd[0], {cfg[15:8], cfg[7:0], 8'h9C, 8'h1C});
      chk("ilas_first_k", 32'(txk[0]), 32'h3);
      repeat (31) tick();
      chk("ilas_a", txd[0], 32'h7C7E7D7C);
      chk("ilas_a_k", 32'(txk[0]), 32'h8);
      repeat (95) tick();
      chk("ilas_len", 32'(ls[0]), 32'd1);
      tick();
      chk("data_start", 32'(ls[0]), 32'd2);

      // Replacement, mid-multiframe and on the boundary
      run(64, 0);
      wait_lmfc(0, 5);
      din = 32'h44332211;
      tick();
      din = 32'h44776655;
      tick();
      chk("repl_fc", txd[0], 32'hFC776655);
      chk("repl_fc_k", 32'(txk[0]), 32'h8);
      wait_lmfc(0, 30);
      din = 32'h44332211;
      tick();
      din = 32'h44776655;
      tick();
      chk("repl_7c", txd[0], 32'h7C776655);
      chk("repl_7c_k", 32'(txk[0]), 32'h8);
      run(40, 0);

      // One-clock SYNC~ drop; data held so a stale history would show
      sync_n = 1'b0;
      tick();
      sync_n = 1'b1;
      tick();
      chk("resync_read", 32'(rd[0]), 32'd0);
      tick();
      chk("resync_tx", txd[0], 32'hBCBCBCBC);
      chk("resync_state", 32'(ls[0]), 32'd0);
      wait_state(0, 2, 300);
      repeat (3) tick();
      run(50, 0);

      // SYSREF realign in CGS
      sync_n = 1'b0;
      repeat (3) tick();
      wait_lmfc(0, 17);
      sysref = 1'b1;
      tick();
      sysref = 1'b0;
      repeat (31) tick();
      chk("sysref_p1", 32'(pls[0]), 32'd1);
      repeat (32) tick();
      chk("sysref_p2", 32'(pls[0]), 32'd1);

      // SYSREF realign inside ILAS restarts all four multiframes
      sync_n = 1'b1;
      wait_state(0, 1, 100);
      repeat (50) tick();
      sysref = 1'b1;
      tick();
      sysref = 1'b0;
      repeat (127) tick();
      chk("ilas_rerun", 32'(ls[0]), 32'd1);
      tick();
      chk("ilas_rerun_end", 32'(ls[0]), 32'd2);
      run(300, 100);

      // Asynchronous reset in the middle of ILAS
      sync_n = 1'b0;
      repeat (3) tick();
      sync_n = 1'b1;
      wait_state(0, 1, 100);
      repeat (20) tick();
      rst = 1'b1;
      model_reset();
      #1;
      chk("arst_tx", txd[0], 32'hBCBCBCBC);
      chk("arst_k", 32'(txk[0]), 32'hF);
      chk("arst_state", 32'(ls[0]), 32'd0);
      check_all();
      repeat (2) tick();
      rst = 1'b0;
      wait_state(0, 2, 300);
      run(100, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
